// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ack handshake,
// and queues up to two returned words for the parser with a redirect-driven flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] p_count,
  output logic        inst_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  logic [1:0]        state;
  logic [31:0]       pc;
  logic [31:0]       req_addr;
  logic [1:0][31:0]  q_instr;
  logic [1:0][31:0]  q_pc;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic [1:0]        count_next;
  logic [31:0]       next_addr;
  logic [31:0]       target;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign target     = {redirect_pc[31:2], 2'b00};
  assign next_addr  = req_addr + 32'd4;
  assign pop        = inst_valid && !stall && !redirect;
  assign push       = imem_ack && (state == FETCH) && !redirect;
  assign count_next = count + 2'(push) - 2'(pop);

  assign inst_valid  = (count != 2'd0);
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = req_addr;
  assign instruction = q_instr[rd_ptr];
  assign p_count     = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC_AL;
      req_addr <= RESET_PC_AL;
      q_instr  <= '0;
      q_pc     <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      // FETCH never holds more than one queued entry, so a push always finds a free slot
      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= next_addr;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      if (redirect) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pc     <= target;
        // A read still in flight must complete before the target can be requested
        if (imem_req && !imem_ack) begin
          state <= DRAIN;
        end else begin
          state    <= FETCH;
          req_addr <= target;
        end
      end else begin
        count <= count_next;
        case (state)
          IDLE: begin
            if (count_next <= 2'd1) begin
              state    <= FETCH;
              req_addr <= pc;
            end
          end
          FETCH: begin
            if (imem_ack) begin
              pc <= next_addr;
              if (count_next <= 2'd1) begin
                req_addr <= next_addr;
              end else begin
                state <= IDLE;
              end
            end
          end
          DRAIN: begin
            if (imem_ack) begin
              state    <= FETCH;
              req_addr <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a latency-configurable memory responder plus an address-stream
// model of which instruction the parser should see next.
module tb_inst_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] p_count;
  logic        inst_valid;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .p_count(p_count), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: address the parser must see next, and memory wait bookkeeping
  logic [31:0] exp_pc;
  int          wcnt, lat_cur, lat_fix, pops, nv;
  bit          rand_lat = 1'b0;
  logic        prev_req, prev_ack, prev_redir;
  logic [31:0] prev_addr, old_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic model_reset();
    exp_pc     = RPC;
    wcnt       = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_redir = 1'b0;
    lat_cur    = rand_lat ? int'($urandom_range(0, 3)) : lat_fix;
  endtask

  // One clock: respond as memory, advance the model, then check after the edge
  task automatic tick();
    imem_ack   = imem_req && (wcnt >= lat_cur);
    imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
    if (inst_valid && !stall && !redirect) begin
      exp_pc += 32'd4;
      pops++;
    end
    if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    prev_req   = imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_redir = redirect;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (prev_req && !prev_ack) begin
      wcnt++;
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end else begin
      wcnt    = 0;
      lat_cur = rand_lat ? int'($urandom_range(0, 3)) : lat_fix;
    end
    if (prev_redir) chk("flush_valid", 32'(inst_valid), 32'd0);
    if (inst_valid) begin
      chk("head_instr", instruction, memf(exp_pc));
      chk("head_pcount", p_count, exp_pc + 32'd4);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    lat_fix = 0;
    pops    = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_pcount", p_count, 32'd0);
    chk("reset_addr", imem_addr, RPC);
    reset_n = 1'b1;

    // Zero-wait memory, no stall: one instruction per cycle
    tick();
    chk("zw_req", 32'(imem_req), 32'd1);
    chk("zw_addr0", imem_addr, 32'h100);
    chk("zw_v0", 32'(inst_valid), 32'd0);
    tick();
    chk("zw_addr1", imem_addr, 32'h104);
    chk("zw_pc1", p_count, 32'h104);
    tick();
    chk("zw_addr2", imem_addr, 32'h108);
    chk("zw_pc2", p_count, 32'h108);
    repeat (20) begin
      tick();
      chk("zw_stream_valid", 32'(inst_valid), 32'd1);
    end

    // Stall until the queue fills, then release
    stall = 1'b1;
    do_reset();
    repeat (5) tick();
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_hold", instruction, memf(32'h100));
    stall = 1'b0;
    tick();
    chk("stall_resume_req", 32'(imem_req), 32'd1);
    chk("stall_resume_addr", imem_addr, 32'h108);
    repeat (6) tick();

    // 3-cycle-wait memory: one valid cycle in every four
    lat_fix = 3;
    do_reset();
    repeat (4) tick();
    nv = 0;
    repeat (16) begin
      tick();
      if (inst_valid) nv++;
    end
    chk("wait3_pulses", 32'(nv), 32'd4);

    // Redirect while the read of 0x108 is outstanding
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h108 && wcnt == 0); i++) tick();
    chk("rd_reach_108", imem_addr, 32'h108);
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    tick();
    chk("rd_drain_req", 32'(imem_req), 32'd1);
    chk("rd_drain_addr", imem_addr, 32'h108);
    for (int i = 0; i < 10 && imem_addr == 32'h108; i++) tick();
    chk("rd_new_addr", imem_addr, 32'h2000);
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    chk("rd_first_pcount", p_count, 32'h2004);

    // Redirect coinciding with ack and pop
    lat_fix = 0;
    do_reset();
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    chk("same_req", 32'(imem_req), 32'd1);
    chk("same_addr", imem_addr, 32'h3000);
    tick();
    chk("same_first_valid", 32'(inst_valid), 32'd1);

    // Two redirects while draining: the later target wins
    lat_fix = 3;
    for (int i = 0; i < 20 && !(imem_req && wcnt == 0 && lat_cur == 3); i++) tick();
    old_addr = imem_addr;
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h5000;
    tick();
    chk("dd_still_old", imem_addr, old_addr);
    for (int i = 0; i < 10 && imem_addr == old_addr; i++) tick();
    chk("dd_later_wins", imem_addr, 32'h5000);

    // PC wrap at the top of the address space
    lat_fix = 0;
    for (int i = 0; i < 20 && !(wcnt == 0 && lat_cur == 0); i++) tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pcount", p_count, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Asynchronous reset while a read is waiting
    lat_fix = 3;
    do_reset();
    for (int i = 0; i < 20 && !(imem_req && wcnt == 1); i++) tick();
    #2;
    do_reset();
    tick();
    chk("rerst_req", 32'(imem_req), 32'd1);
    chk("rerst_addr", imem_addr, RPC);

    // Randomized stall, redirect and memory latency
    rand_lat = 1'b1;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
      end
      tick();
    end
    chk("rand_progress", 32'(pops > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the instruction parser. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a 2-entry queue and presents `instruction` and `p_count` (address+4) to the parser with a valid/stall handshake. Accepts a one-cycle redirect (branch/jump target) that flushes queued and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] forced to 0.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream not accepting; head entry is held.
- `redirect`  in  1  one-cycle pulse; load new PC and flush.
- `redirect_pc`  in  32  target address; bits [1:0] ignored (treated as 00).
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req` high.
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  read data.
- `instruction`  out  32  head-of-queue instruction word.
- `p_count`  out  32  head-of-queue fetch address + 4.
- `inst_valid`  out  1  head entry valid (queue count != 0).

## Operation
- Registers: `pc` (next address to fetch), `req_addr` (address of outstanding read), 2-entry FIFO of {instruction, p_count}, count 0..2, FSM state.
- FSM states: IDLE (no request), FETCH (request outstanding, result kept), DRAIN (request outstanding, result discarded).
- Pop: `inst_valid && !stall && !redirect`. Push: `imem_ack` in FETCH with no redirect. count_next = count + push - pop.
- IDLE -> FETCH when count_next <= 1; `req_addr` <= `pc`.
- FETCH, no ack: stay; `imem_req`/`imem_addr` held.
- FETCH, ack: push {`imem_rdata`, `req_addr`+4}; `pc` <= `req_addr`+4. Stay FETCH with `req_addr` <= `req_addr`+4 if count_next <= 1, else -> IDLE.
- Redirect (highest priority, any state): FIFO flushed (count <= 0); `pc` <= {`redirect_pc`[31:2],2'b00}. Next state: DRAIN if a request is outstanding and `imem_ack` is low this cycle; otherwise FETCH with `req_addr` <= new pc. Data acked in the redirect cycle is discarded.
- DRAIN: `imem_req` stays high at the old `req_addr`. On ack, discard data and -> FETCH with `req_addr` <= `pc`. A redirect during DRAIN updates `pc` and stays in DRAIN.
- `imem_req` = state is FETCH or DRAIN. `imem_addr` = `req_addr`.
- PC arithmetic: 32-bit unsigned, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, giving `p_count` 0.
- Reset values: state IDLE, `pc` = `req_addr` = RESET_PC, count 0, `inst_valid` 0, `imem_req` 0, `instruction` 0, `p_count` 0.
- `instruction`/`p_count` are don't-care while `inst_valid` = 0.

## Timing
- At most one memory request is outstanding. `imem_req` never drops before ack.
- First `imem_req` is asserted on the first clock edge after `reset_n` deasserts (IDLE -> FETCH).
- Zero-wait memory (ack in the request cycle): data is visible on `inst_valid`/`instruction` the next cycle. Sustained throughput is 1 instruction/cycle with `stall` = 0.
- N-cycle-wait memory: `inst_valid` rises the cycle after the ack cycle.
- Stall with queue full (count 2): no request is issued; fetch resumes the cycle after the first pop.
- Redirect in cycle T: `inst_valid` = 0 in T+1. With ack in T or no outstanding request, the new request is issued in T+1. Otherwise the old request drains first.
- Reset asserted mid-operation: all state clears immediately (asynchronous), including any outstanding request. The memory must tolerate `imem_req` dropping on reset.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, `stall`=0 -> `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `p_count` 0x104, 0x108, 0x10C; `inst_valid` high continuously from cycle 2.
- Hold `stall`=1 for 5 cycles from 0x100 -> count reaches 2; `imem_req` low; `instruction` holds word@0x100. Release -> words @0x100, 0x104, 0x108 arrive in order with none lost or duplicated.
- 3-cycle-wait memory -> `imem_addr` stable 0x100 while `imem_req` high; `inst_valid` pulses once every 4 cycles.
- Redirect to 0x2003 while a read of 0x108 is outstanding -> `inst_valid` 0 next cycle; DRAIN; ack for 0x108 discarded; next `imem_addr` 0x2000; first valid `p_count` 0x2004.
- Redirect in the same cycle as ack and pop -> FIFO empty next cycle; acked data dropped; new fetch of the target starts next cycle. Redirect again during DRAIN -> the later target wins.
- PC 0xFFFF_FFFC fetched -> `p_count` 0x0, next `imem_addr` 0x0. Assert `reset_n`=0 mid-wait -> `imem_req` and `inst_valid` drop immediately; refetch from RESET_PC after release.
